alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- Issue/decode stage that drives the ALU: it takes decoded instruction fields (ALUOp, funct, operands, destination tag) and produces the 4-bit ALU control code and registered operands for the ALU.
- Sits between the register-read stage and the ALU, the producer end of the ALU's a/b/ALU_ctl interface.
- A 2-entry skid buffer with valid/ready on both sides lets upstream ready be a registered signal and absorbs one cycle of downstream backpressure without data loss.

Parameters:
- DATA_W, 32, operand width.
- TAG_W, 5, destination register tag width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous clear of all buffered entries (branch redirect).
- in_valid  input  1  upstream entry present.
- in_ready  output  1  stage can accept; registered.
- in_alu_op  input  2  ALUOp from main control.
- in_funct  input  6  R-type funct field.
- in_a  input  DATA_W  source operand 1.
- in_b  input  DATA_W  source operand 2.
- in_rd  input  TAG_W  destination tag.
- out_valid  output  1  entry presented to ALU.
- out_ready  input  1  ALU/EX side consumes the entry.
- out_a  output  DATA_W  operand to ALU a.
- out_b  output  DATA_W  operand to ALU b.
- out_alu_ctl  output  4  ALU control code.
- out_rd  output  TAG_W  tag travelling with the entry.
- out_illegal  output  1  entry decoded to an unsupported operation.

Behaviour:
- Decode is combinational on input fields and is captured at acceptance. Nothing is re-decoded later.
- ALUOp 00 gives 0010 (add, load/store address).
- ALUOp 01 gives 0110 (sub, branch compare).
- ALUOp 10 decodes funct:
  - 100000 gives 0010 (add).
  - 100010 gives 0110 (sub).
  - 100100 gives 0000 (and).
  - 100101 gives 0001 (or).
  - 101010 gives 0111 (slt).
  - Any other funct gives 1111 with illegal=1.
- ALUOp 11 gives 1111 with illegal=1.
- Code 1111 makes the ALU output 0. The entry is still issued, with out_illegal=1.
- Storage is a main register M (drives the out_* ports) and a skid register S. Each has a valid bit.
- Handshakes:
  - Input transfer: in_valid & in_ready.
  - Output transfer: out_valid & out_ready.
  - out_valid = M.valid.
  - in_ready = ~S.valid, registered from next-state.
- Per cycle, without flush:
  - Output transfer and S valid: S moves to M. If an input is also transferred, it goes to S.
  - Output transfer and S empty: an incoming input loads M; with no input, M becomes invalid.
  - No output transfer and M empty: an input loads M.
  - No output transfer and M valid: an input loads S.
- Throughput: 1 entry/cycle with out_ready held high. Latency from input transfer to out_valid is 1 cycle.
- out_* data is stable while out_valid=1 and out_ready=0. Entries are never reordered or duplicated.
- flush=1: M.valid and S.valid clear next cycle and in_ready=1 next cycle. An input transfer in the same cycle is dropped. An output transfer in the same cycle completes normally, since the downstream side saw it.
- rst=1, including mid-operation:
  - out_valid=0.
  - in_ready=1 after the reset edge.
  - out_a=0, out_b=0, out_alu_ctl=0000, out_rd=0, out_illegal=0.
  - rst has priority over flush.
- Data registers may hold stale values while invalid. Only the valid bits are architecturally meaningful, apart from the reset values above.

Optional Feature:
- Macro ALU_NOR_EN.
- When defined: ALUOp 10 with funct 100111 decodes to 1100 (nor) with illegal=0. The ALU must implement 1100 in the same build.
- When undefined: funct 100111 gives 1111 with illegal=1, like any other unsupported funct.

Test Plan:
1. Reset then stream with out_ready=1:
   - Stimulus: in_alu_op=10, in_funct=100000, in_a=5, in_b=7, in_rd=3.
   - Response: next cycle out_valid=1, out_alu_ctl=0010, out_a=5, out_b=7, out_rd=3.
   - Follow with 4 back-to-back ops (sub/and/or/slt). Outputs appear in order at 1/cycle with codes 0110, 0000, 0001, 0111.
2. Backpressure:
   - Stimulus: out_ready=0 while 2 entries (A, B) are sent.
   - Response: after A in M and B in S, in_ready=0. A third offered entry is not accepted. out_* holds A.
   - Then raise out_ready. A, then B, then the third entry emerge in consecutive cycles, and in_ready returns to 1.
3. Illegal decode:
   - Stimulus: in_alu_op=11, and separately in_alu_op=10 with in_funct=000011.
   - Response: out_alu_ctl=1111 and out_illegal=1 for both. Next legal op shows out_illegal=0.
4. Flush with both entries full plus flush and in_valid in the same cycle:
   - Response: next cycle out_valid=0 and in_ready=1. The concurrently offered input never appears at the output.
5. Mid-stream reset:
   - Stimulus: rst=1 while M and S are valid and out_ready=0.
   - Response: after the edge, out_valid=0, in_ready=1, out_alu_ctl=0000, out_illegal=0.
6. ALU_NOR_EN:
   - Stimulus: in_alu_op=10, in_funct=100111.
   - Response with macro defined: out_alu_ctl=1100, out_illegal=0. Response without macro: 1111 with out_illegal=1.

Source files
------------

// File: rtl/alu_issue_stage_if.sv
// Bundled handshake/payload signals between register-read, the issue stage and the ALU.
// slave is the issue stage's view; master is the surrounding environment.
interface alu_issue_stage_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAG_W  = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_alu_op;
    logic [5:0]        in_funct;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic [TAG_W-1:0]  in_rd;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_a;
    logic [DATA_W-1:0] out_b;
    logic [3:0]        out_alu_ctl;
    logic [TAG_W-1:0]  out_rd;
    logic              out_illegal;

    modport slave (
        input  in_valid, in_alu_op, in_funct, in_a, in_b, in_rd, out_ready,
        output in_ready, out_valid, out_a, out_b, out_alu_ctl, out_rd, out_illegal
    );

    modport master (
        output in_valid, in_alu_op, in_funct, in_a, in_b, in_rd, out_ready,
        input  in_ready, out_valid, out_a, out_b, out_alu_ctl, out_rd, out_illegal
    );
endinterface

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes ALUOp/funct to a 4-bit ALU control code and holds entries in a 2-deep skid buffer.
// Optional macro ALU_NOR_EN enables the nor encoding (funct 100111 -> 1100).
module alu_issue_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAG_W  = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    alu_issue_stage_if.slave   bus
);
    localparam int unsigned CTL_W = 4;
    localparam logic [CTL_W-1:0] CTL_AND = 4'b0000;
    localparam logic [CTL_W-1:0] CTL_OR  = 4'b0001;
    localparam logic [CTL_W-1:0] CTL_ADD = 4'b0010;
    localparam logic [CTL_W-1:0] CTL_SUB = 4'b0110;
    localparam logic [CTL_W-1:0] CTL_SLT = 4'b0111;
    localparam logic [CTL_W-1:0] CTL_BAD = 4'b1111;
`ifdef ALU_NOR_EN
    localparam logic [CTL_W-1:0] CTL_NOR = 4'b1100;
`endif

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [CTL_W-1:0]  ctl;
        logic [TAG_W-1:0]  rd;
        logic              illegal;
    } entry_t;

    entry_t r_m, r_s, w_m_n, w_s_n, w_dec;
    logic   r_m_valid, r_s_valid, r_in_ready;
    logic   w_m_valid_n, w_s_valid_n;
    logic   w_in_xfer, w_out_xfer;

    // Decode once at acceptance; the captured code travels with the entry.
    always_comb begin
        w_dec.a       = bus.in_a;
        w_dec.b       = bus.in_b;
        w_dec.rd      = bus.in_rd;
        w_dec.ctl     = CTL_BAD;
        w_dec.illegal = 1'b1;
        case (bus.in_alu_op)
            2'b00: begin w_dec.ctl = CTL_ADD; w_dec.illegal = 1'b0; end
            2'b01: begin w_dec.ctl = CTL_SUB; w_dec.illegal = 1'b0; end
            2'b10: begin
                case (bus.in_funct)
                    6'b100000: begin w_dec.ctl = CTL_ADD; w_dec.illegal = 1'b0; end
                    6'b100010: begin w_dec.ctl = CTL_SUB; w_dec.illegal = 1'b0; end
                    6'b100100: begin w_dec.ctl = CTL_AND; w_dec.illegal = 1'b0; end
                    6'b100101: begin w_dec.ctl = CTL_OR;  w_dec.illegal = 1'b0; end
                    6'b101010: begin w_dec.ctl = CTL_SLT; w_dec.illegal = 1'b0; end
`ifdef ALU_NOR_EN
                    6'b100111: begin w_dec.ctl = CTL_NOR; w_dec.illegal = 1'b0; end
`endif
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // Flush drops a same-cycle input but lets a same-cycle output transfer complete.
    assign w_in_xfer  = bus.in_valid & r_in_ready & ~flush;
    assign w_out_xfer = r_m_valid & bus.out_ready;

    always_comb begin
        w_m_n       = r_m;
        w_s_n       = r_s;
        w_m_valid_n = r_m_valid;
        w_s_valid_n = r_s_valid;
        if (flush) begin
            w_m_valid_n = 1'b0;
            w_s_valid_n = 1'b0;
        end else if (w_out_xfer) begin
            if (r_s_valid) begin
                w_m_n       = r_s;
                w_s_valid_n = w_in_xfer;
                if (w_in_xfer) w_s_n = w_dec;
            end else begin
                w_m_valid_n = w_in_xfer;
                if (w_in_xfer) w_m_n = w_dec;
            end
        end else if (w_in_xfer) begin
            if (!r_m_valid) begin
                w_m_n       = w_dec;
                w_m_valid_n = 1'b1;
            end else begin
                w_s_n       = w_dec;
                w_s_valid_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_m        <= '0;
            r_s        <= '0;
            r_m_valid  <= 1'b0;
            r_s_valid  <= 1'b0;
            r_in_ready <= 1'b1;
        end else begin
            r_m        <= w_m_n;
            r_s        <= w_s_n;
            r_m_valid  <= w_m_valid_n;
            r_s_valid  <= w_s_valid_n;
            r_in_ready <= ~w_s_valid_n;
        end
    end

    assign bus.in_ready    = r_in_ready;
    assign bus.out_valid   = r_m_valid;
    assign bus.out_a       = r_m.a;
    assign bus.out_b       = r_m.b;
    assign bus.out_alu_ctl = r_m.ctl;
    assign bus.out_rd      = r_m.rd;
    assign bus.out_illegal = r_m.illegal;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: FIFO-level reference model checked every cycle plus literal spot checks.
module tb_alu_issue_stage;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned TAG_W  = 5;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    always #5 clk = ~clk;

    alu_issue_stage_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

    alu_issue_stage #(.DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctl;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   chk_en = 1'b0;
    logic [5:0] fset [0:7] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd39, 6'd3, 6'd0};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode straight from the opcode table.
    function automatic logic [4:0] dec(input logic [1:0] op, input logic [5:0] f);
        if (op == 2'd0) return 5'b0_0010;
        if (op == 2'd1) return 5'b0_0110;
        if (op == 2'd3) return 5'b1_1111;
        case (f)
            6'd32:   return 5'b0_0010;
            6'd34:   return 5'b0_0110;
            6'd36:   return 5'b0_0000;
            6'd37:   return 5'b0_0001;
            6'd42:   return 5'b0_0111;
`ifdef ALU_NOR_EN
            6'd39:   return 5'b0_1100;
`endif
            default: return 5'b1_1111;
        endcase
    endfunction

    // Stage modelled as an in-order queue of at most two entries.
    task automatic model_update();
        bit         acc;
        exp_t       e;
        logic [4:0] d;
        acc = bus.in_valid && (q.size() < 2) && !flush;
        if (rst) begin
            q.delete();
        end else begin
            if (q.size() > 0 && bus.out_ready) void'(q.pop_front());
            if (flush) q.delete();
            else if (acc) begin
                d     = dec(bus.in_alu_op, bus.in_funct);
                e.a   = bus.in_a;
                e.b   = bus.in_b;
                e.rd  = bus.in_rd;
                e.ctl = d[3:0];
                e.ill = d[4];
                q.push_back(e);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [5:0] f,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        bus.in_valid  = 1'b1;
        bus.in_alu_op = op;
        bus.in_funct  = f;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_rd     = rd;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_valid", 64'(bus.out_valid), 64'(q.size() > 0));
            chk("in_ready",  64'(bus.in_ready),  64'(q.size() < 2));
            if (q.size() > 0) begin
                chk("out_a",       64'(bus.out_a),       64'(q[0].a));
                chk("out_b",       64'(bus.out_b),       64'(q[0].b));
                chk("out_alu_ctl", 64'(bus.out_alu_ctl), 64'(q[0].ctl));
                chk("out_rd",      64'(bus.out_rd),      64'(q[0].rd));
                chk("out_illegal", 64'(bus.out_illegal), 64'(q[0].ill));
            end
        end
    end

    logic [3:0] t1_ctl [0:3] = '{4'b0110, 4'b0000, 4'b0001, 4'b0111};
    logic [5:0] t1_fn  [0:3] = '{6'd34, 6'd36, 6'd37, 6'd42};

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_alu_op = 2'd0;
        bus.in_funct = 6'd0;
        bus.in_a = '0;
        bus.in_b = '0;
        bus.in_rd = '0;
        tick();
        tick();
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
        chk("rst_ctl",       64'(bus.out_alu_ctl), 64'd0);
        chk("rst_a",         64'(bus.out_a), 64'd0);
        chk("rst_b",         64'(bus.out_b), 64'd0);
        chk("rst_rd",        64'(bus.out_rd), 64'd0);
        chk("rst_illegal",   64'(bus.out_illegal), 64'd0);
        chk_en = 1'b1;
        rst = 1'b0;

        // Streaming at one entry per cycle
        bus.out_ready = 1'b1;
        send(2'b10, 6'b100000, 32'd5, 32'd7, 5'd3);
        tick();
        chk("t1_valid", 64'(bus.out_valid), 64'd1);
        chk("t1_ctl",   64'(bus.out_alu_ctl), 64'b0010);
        chk("t1_a",     64'(bus.out_a), 64'd5);
        chk("t1_b",     64'(bus.out_b), 64'd7);
        chk("t1_rd",    64'(bus.out_rd), 64'd3);
        for (int i = 0; i < 4; i++) begin
            send(2'b10, t1_fn[i], 32'(i + 10), 32'(i + 20), 5'(i + 4));
            tick();
            chk("t1_stream_ctl", 64'(bus.out_alu_ctl), 64'(t1_ctl[i]));
            chk("t1_stream_a",   64'(bus.out_a), 64'(i + 10));
        end
        idle();
        tick();

        // Backpressure fills M then S
        bus.out_ready = 1'b0;
        send(2'b00, 6'd0, 32'd100, 32'd1, 5'd1);
        tick();
        send(2'b01, 6'd0, 32'd200, 32'd2, 5'd2);
        tick();
        chk("t2_full_ready", 64'(bus.in_ready), 64'd0);
        chk("t2_hold_a",     64'(bus.out_a), 64'd100);
        send(2'b10, 6'b100100, 32'd300, 32'd3, 5'd3);
        tick();
        chk("t2_stall_ready", 64'(bus.in_ready), 64'd0);
        chk("t2_stall_a",     64'(bus.out_a), 64'd100);
        bus.out_ready = 1'b1;
        tick();
        chk("t2_drain_b", 64'(bus.out_a), 64'd200);
        tick();
        idle();
        chk("t2_drain_c",  64'(bus.out_a), 64'd300);
        chk("t2_ready_up", 64'(bus.in_ready), 64'd1);
        tick();
        chk("t2_empty", 64'(bus.out_valid), 64'd0);

        // Illegal decodes
        send(2'b11, 6'd0, 32'd1, 32'd1, 5'd1);
        tick();
        chk("t3_op11_ctl", 64'(bus.out_alu_ctl), 64'b1111);
        chk("t3_op11_ill", 64'(bus.out_illegal), 64'd1);
        send(2'b10, 6'b000011, 32'd2, 32'd2, 5'd2);
        tick();
        chk("t3_fn_ctl", 64'(bus.out_alu_ctl), 64'b1111);
        chk("t3_fn_ill", 64'(bus.out_illegal), 64'd1);
        send(2'b00, 6'd0, 32'd3, 32'd3, 5'd3);
        tick();
        chk("t3_legal_ill", 64'(bus.out_illegal), 64'd0);
        idle();
        tick();

        // Flush with both entries full and a concurrent input
        bus.out_ready = 1'b0;
        send(2'b00, 6'd0, 32'd11, 32'd0, 5'd1);
        tick();
        send(2'b00, 6'd0, 32'd12, 32'd0, 5'd2);
        tick();
        flush = 1'b1;
        send(2'b00, 6'd0, 32'hDEAD, 32'd0, 5'd9);
        tick();
        flush = 1'b0;
        idle();
        chk("t4_valid", 64'(bus.out_valid), 64'd0);
        chk("t4_ready", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b1;
        tick();
        tick();
        chk("t4_dropped", 64'(bus.out_valid), 64'd0);

        // Reset while both entries are held
        bus.out_ready = 1'b0;
        send(2'b10, 6'b100101, 32'd21, 32'd0, 5'd1);
        tick();
        send(2'b10, 6'b101010, 32'd22, 32'd0, 5'd2);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        chk("t5_valid",   64'(bus.out_valid), 64'd0);
        chk("t5_ready",   64'(bus.in_ready), 64'd1);
        chk("t5_ctl",     64'(bus.out_alu_ctl), 64'd0);
        chk("t5_illegal", 64'(bus.out_illegal), 64'd0);

        // Optional nor encoding
        bus.out_ready = 1'b1;
        send(2'b10, 6'b100111, 32'd31, 32'd32, 5'd7);
        tick();
        idle();
`ifdef ALU_NOR_EN
        chk("t6_ctl", 64'(bus.out_alu_ctl), 64'b1100);
        chk("t6_ill", 64'(bus.out_illegal), 64'd0);
`else
        chk("t6_ctl", 64'(bus.out_alu_ctl), 64'b1111);
        chk("t6_ill", 64'(bus.out_illegal), 64'd1);
`endif
        tick();

        // Randomized traffic with occasional flush and reset
        for (int i = 0; i < 3000; i++) begin
            send(2'($urandom_range(0, 3)), fset[$urandom_range(0, 7)],
                 $urandom(), $urandom(), 5'($urandom()));
            if ($urandom_range(0, 7) == 0) bus.in_funct = 6'($urandom());
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 24) == 0);
            rst   = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 1'b0;
        flush = 1'b0;
        idle();
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
